// File: rtl/turn_tracker_if.sv
// Decoder/hand-manager facing bundle for turn_tracker: decoded card fields and
// turn-control pulses in, turn counters and result pulses out.
interface turn_tracker_if;
    logic [2:0] mode;
    logic       nextcard;
    logic [2:0] ibuy;
    logic [2:0] iaction;
    logic [2:0] idraw;
    logic [4:0] igold;
    logic       start_turn;
    logic       action_done;
    logic       buy_req;
    logic [3:0] buy_cost;
    logic       end_turn;
    logic       draw_ack;

    logic [4:0] gold_in_bank;
    logic [3:0] actions_left;
    logic [3:0] buys_left;
    logic [3:0] draw_pending;
    logic [1:0] phase;
    logic       buy_ok;
    logic       buy_err;
    logic       play_err;
    logic       turn_done;
    logic [6:0] vp_total;

    modport master (
        output mode, nextcard, ibuy, iaction, idraw, igold,
               start_turn, action_done, buy_req, buy_cost, end_turn, draw_ack,
        input  gold_in_bank, actions_left, buys_left, draw_pending, phase,
               buy_ok, buy_err, play_err, turn_done, vp_total
    );

    modport slave (
        input  mode, nextcard, ibuy, iaction, idraw, igold,
               start_turn, action_done, buy_req, buy_cost, end_turn, draw_ack,
        output gold_in_bank, actions_left, buys_left, draw_pending, phase,
               buy_ok, buy_err, play_err, turn_done, vp_total
    );
endinterface

// File: rtl/turn_tracker.sv
// Per-turn resource accumulator: tracks actions, buys, gold and owed draws
// through IDLE/ACT/BUY/CLEANUP, validates purchases and totals endgame VP.
module turn_tracker #(
    parameter int unsigned MAXGOLD = 31
) (
    input  logic           clk,
    input  logic           reset,
    turn_tracker_if.slave  bus
);
    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_ACT     = 2'd1;
    localparam logic [1:0] PH_BUY     = 2'd2;
    localparam logic [1:0] PH_CLEANUP = 2'd3;

    localparam logic [2:0] MODE_ACTION   = 3'd1;
    localparam logic [2:0] MODE_TREASURE = 3'd2;
    localparam logic [2:0] MODE_ENDGAME  = 3'd7;

    localparam logic [5:0] GOLD_MAX = 6'(MAXGOLD);

    logic [1:0] phase_q, phase_d;
    logic [3:0] actions_q, actions_d;
    logic [3:0] buys_q, buys_d;
    logic [4:0] gold_q, gold_d;
    logic [3:0] draw_q, draw_d;
    logic [6:0] vp_q, vp_d;
    logic [2:0] mode_q, mode_d;
    logic       buy_ok_q, buy_ok_d;
    logic       buy_err_q, buy_err_d;
    logic       play_err_q, play_err_d;
    logic       turn_done_q, turn_done_d;

    logic       endgame, card_act, card_tre;
    logic [3:0] draw_add;
    logic [4:0] gold_add;
    logic [6:0] vp_base;
    logic [7:0] vp_sum;

    function automatic logic [3:0] sat4(input logic [4:0] v);
        return (v > 5'd15) ? 4'd15 : v[3:0];
    endfunction

    function automatic logic [4:0] sat_gold(input logic [5:0] v);
        return (v > GOLD_MAX) ? GOLD_MAX[4:0] : v[4:0];
    endfunction

    always_comb begin
        phase_d     = phase_q;
        actions_d   = actions_q;
        buys_d      = buys_q;
        gold_d      = gold_q;
        draw_d      = draw_q;
        vp_d        = vp_q;
        mode_d      = bus.mode;
        buy_ok_d    = 1'b0;
        buy_err_d   = 1'b0;
        play_err_d  = 1'b0;
        draw_add    = draw_q;
        gold_add    = gold_q;
        vp_base     = vp_q;
        vp_sum      = '0;

        endgame  = (bus.mode == MODE_ENDGAME);
        card_act = bus.nextcard && (bus.mode == MODE_ACTION);
        card_tre = bus.nextcard && (bus.mode == MODE_TREASURE);

        if (endgame) begin
            vp_base = (mode_q != MODE_ENDGAME) ? '0 : vp_q;
            vp_sum  = {1'b0, vp_base} + {3'b000, bus.igold};
            vp_d    = !bus.nextcard ? vp_base
                    : (vp_sum > 8'd127) ? 7'd127 : vp_sum[6:0];
        end

        // ENDGAME freezes the turn, but a CLEANUP already entered still completes
        if (!endgame || phase_q == PH_CLEANUP) begin
            case (phase_q)
                PH_IDLE: begin
                    if (bus.start_turn) begin
                        actions_d = 4'd1;
                        buys_d    = 4'd1;
                        gold_d    = '0;
                        draw_add  = '0;
                        phase_d   = PH_ACT;
                    end
                end
                PH_ACT: begin
                    if (card_act) begin
                        if (actions_q != '0) begin
                            actions_d = sat4({1'b0, actions_q} - 5'd1 + {2'b00, bus.iaction});
                            buys_d    = sat4({1'b0, buys_q} + {2'b00, bus.ibuy});
                            gold_d    = sat_gold({1'b0, gold_q} + {1'b0, bus.igold});
                            draw_add  = sat4({1'b0, draw_q} + {2'b00, bus.idraw});
                        end else begin
                            play_err_d = 1'b1;
                        end
                    end
                    if (bus.action_done) phase_d = PH_BUY;
                end
                PH_BUY: begin
                    gold_add = card_tre ? sat_gold({1'b0, gold_q} + {1'b0, bus.igold}) : gold_q;
                    gold_d   = gold_add;
                    // legality is judged on registered gold; a same-cycle treasure only adds to the result
                    if (bus.buy_req) begin
                        if (buys_q != '0 && gold_q >= {1'b0, bus.buy_cost}) begin
                            gold_d   = gold_add - {1'b0, bus.buy_cost};
                            buys_d   = buys_q - 4'd1;
                            buy_ok_d = 1'b1;
                            if (buys_q == 4'd1) phase_d = PH_CLEANUP;
                        end else begin
                            buy_err_d = 1'b1;
                        end
                    end
                    if (bus.end_turn) phase_d = PH_CLEANUP;
                end
                default: begin
                    actions_d = '0;
                    buys_d    = '0;
                    gold_d    = '0;
                    phase_d   = PH_IDLE;
                end
            endcase
            if (!endgame) begin
                draw_d = (bus.draw_ack && draw_add != '0) ? draw_add - 4'd1 : draw_add;
            end
        end

        turn_done_d = (phase_d == PH_CLEANUP) && (phase_q != PH_CLEANUP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q     <= PH_IDLE;
            actions_q   <= '0;
            buys_q      <= '0;
            gold_q      <= '0;
            draw_q      <= '0;
            vp_q        <= '0;
            mode_q      <= '0;
            buy_ok_q    <= 1'b0;
            buy_err_q   <= 1'b0;
            play_err_q  <= 1'b0;
            turn_done_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            actions_q   <= actions_d;
            buys_q      <= buys_d;
            gold_q      <= gold_d;
            draw_q      <= draw_d;
            vp_q        <= vp_d;
            mode_q      <= mode_d;
            buy_ok_q    <= buy_ok_d;
            buy_err_q   <= buy_err_d;
            play_err_q  <= play_err_d;
            turn_done_q <= turn_done_d;
        end
    end

    assign bus.gold_in_bank = gold_q;
    assign bus.actions_left = actions_q;
    assign bus.buys_left    = buys_q;
    assign bus.draw_pending = draw_q;
    assign bus.phase        = phase_q;
    assign bus.buy_ok       = buy_ok_q;
    assign bus.buy_err      = buy_err_q;
    assign bus.play_err     = play_err_q;
    assign bus.turn_done    = turn_done_q;
    assign bus.vp_total     = vp_q;
endmodule
